rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width of the register file.
REQ-002 SHALL have parameter AW, default 5, the register address width (2^AW registers).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous active-high reset, sampled on rising CLK.
REQ-005 SHALL have port req0_valid, input, 1 bit: the ALU writeback request.
REQ-006 SHALL have port req0_addr, input, AW bits: the ALU destination register.
REQ-007 SHALL have port req0_data, input, XLEN bits: the ALU writeback data.
REQ-008 SHALL have port req0_ready, output, 1 bit: the ALU request is accepted this cycle.
REQ-009 SHALL have port req1_valid, input, 1 bit: the load-unit writeback request.
REQ-010 SHALL have port req1_addr, input, AW bits: the load-unit destination register.
REQ-011 SHALL have port req1_data, input, XLEN bits: the load-unit writeback data.
REQ-012 SHALL have port req1_ready, output, 1 bit: the load-unit request is accepted this cycle.
REQ-013 SHALL have port clr_start, input, 1 bit: a one-cycle request to zero the register file.
REQ-014 SHALL have port clr_busy, output, 1 bit: a clear sweep is in progress.
REQ-015 SHALL have port WE3, output, 1 bit: the register-file write enable (registered).
REQ-016 SHALL have port A3, output, AW bits: the register-file write address (registered).
REQ-017 SHALL have port WD3, output, XLEN bits: the register-file write data (registered).

Function
REQ-018 SHALL implement two FSM states: IDLE and CLEAR.
REQ-019 A handshake SHALL occur on reqN when reqN_valid and reqN_ready are both 1 in the same cycle. Ready is combinational from the valids, the state and the round-robin pointer.
REQ-020 In IDLE, ready SHALL be granted to at most one requester per cycle.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester not granted at the last handshake is granted.
REQ-021 The round-robin pointer SHALL update only on a handshake, and SHALL hold otherwise.
REQ-022 A handshake on reqN SHALL produce WE3/A3/WD3 equal to 1/reqN_addr/reqN_data at the next rising edge: one-cycle latency, one write per cycle.
REQ-023 A handshake with reqN_addr == 0 SHALL be accepted with no write: the next-cycle WE3 = 0 and A3/WD3 hold their previous values.
REQ-024 In a cycle with no handshake and no clear write, WE3 SHALL be 0 on the next edge, and A3/WD3 SHALL hold.
REQ-025 clr_start = 1 in IDLE SHALL take priority over any request. In that cycle both readies are 0 and the FSM enters CLEAR on the next edge.
REQ-026 On entering CLEAR, the sweep counter SHALL be set to 1.
REQ-027 In CLEAR, each cycle SHALL register WE3 = 1, A3 = counter and WD3 = 0, then increment the counter.
REQ-028 When the counter equals 2^AW-1, that write SHALL be issued and the FSM SHALL return to IDLE on the same edge. For AW = 5 this is exactly 31 writes, addresses 1..31.
REQ-029 clr_busy SHALL be 1 exactly while the state is CLEAR.
REQ-030 In CLEAR, req0_ready and req1_ready SHALL be 0, and clr_start SHALL be ignored (no restart, no extension).
REQ-031 The round-robin pointer SHALL be unchanged by a clear sweep.
REQ-032 Request inputs SHALL be don't-care while the corresponding valid is 0. A valid request SHALL be held by the requester until its handshake; the block does not buffer it.

Reset
REQ-033 RST = 1 at a rising edge SHALL set:
- state to IDLE and the counter to 0;
- WE3 = 0, A3 = 0, WD3 = 0, clr_busy = 0;
- the round-robin pointer so that req0 wins the first two-way contention.
REQ-034 While RST = 1, req0_ready and req1_ready SHALL be 0.
REQ-035 RST asserted mid-CLEAR SHALL abort the sweep with no further writes, and the block SHALL then behave as after REQ-033.

Verification
REQ-036 Reset, then req0 valid (addr 5, data 0xDEADBEEF) alone -> req0_ready = 1 that cycle; next cycle WE3 = 1, A3 = 5, WD3 = 0xDEADBEEF.
REQ-037 After reset, both valid for 4 cycles (req0 addr 1, req1 addr 2) -> grants req0, req1, req0, req1; A3 sequence 1, 2, 1, 2 with WE3 = 1 each cycle.
REQ-038 req1 valid with addr 0, data 0x1234 -> req1_ready = 1; next cycle WE3 = 0 and A3/WD3 unchanged.
REQ-039 clr_start pulse with req0 valid in the same cycle -> req0_ready = 0; clr_busy = 1 for 31 cycles; WE3 = 1 with A3 = 1..31 and WD3 = 0; then IDLE, and req0 is accepted the first cycle after clr_busy falls.
REQ-040 RST pulse when A3 = 10 during CLEAR -> next edge WE3 = 0, A3 = 0, clr_busy = 0; no write to addresses 11..31.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates two writeback requesters (ALU = req0, load unit = req1) onto a
//   single register-file write port, with round-robin fairness under
//   contention. A clr_start pulse runs a sweep that zeroes registers
//   1..2^AW-1, one per cycle. Writes to register 0 are accepted but dropped.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   req0_valid/addr/data     ALU writeback request;   req0_ready grant
//   req1_valid/addr/data     load writeback request;  req1_ready grant
//   clr_start                one-cycle request to start a clear sweep
//   clr_busy                 clear sweep in progress
//   WE3, A3, WD3             registered register-file write port
module rf_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            WE3,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] WD3
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] CNT_LAST = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  // 1 when req1 won the most recent handshake; req0 wins the next tie.
  logic          last_was1;
  logic          hs0, hs1;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else if (!RST) begin
          if (req0_valid && req1_valid) begin
            req0_ready = last_was1;
            req1_ready = !last_was1;
          end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
          end
        end
      end
      CLEAR: begin
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs0      = req0_valid && req0_ready;
  assign hs1      = req1_valid && req1_ready;
  assign clr_busy = (state == CLEAR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      last_was1 <= 1'b1;
      WE3       <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
    end else begin
      WE3 <= 1'b0;
      if (state == CLEAR) begin
        WE3 <= 1'b1;
        A3  <= cnt;
        WD3 <= '0;
        cnt <= cnt + AW'(1);
      end else begin
        if (clr_start) cnt <= AW'(1);
        // Register 0 is hard-wired: the handshake completes but nothing is
        // written and the previous A3/WD3 are kept.
        if (hs0) begin
          last_was1 <= 1'b0;
          if (req0_addr != '0) begin
            WE3 <= 1'b1;
            A3  <= req0_addr;
            WD3 <= req0_data;
          end
        end else if (hs1) begin
          last_was1 <= 1'b1;
          if (req1_addr != '0) begin
            WE3 <= 1'b1;
            A3  <= req1_addr;
            WD3 <= req1_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req1_valid, clr_start;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, clr_busy, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  rf_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  typedef struct {
    logic        r0v;
    logic [4:0]  r0a;
    logic [31:0] r0d;
    logic        r1v;
    logic [4:0]  r1a;
    logic [31:0] r1d;
    logic        e0;
    logic        e1;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                              input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                              input logic e0, input logic e1, input logic ewe,
                              input logic [4:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
    v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
    v.e0 = e0; v.e1 = e1; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    clr_start  = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3;
    req1_valid = 1'b1; req1_addr = 5'd4;
    #1;
    chk("rst_r0rdy", {31'd0, req0_ready}, 32'd0);
    chk("rst_r1rdy", {31'd0, req1_ready}, 32'd0);
    step();
    chk("rst_we",   {31'd0, WE3}, 32'd0);
    chk("rst_a3",   {27'd0, A3}, 32'd0);
    chk("rst_wd3",  WD3, 32'd0);
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    RST = 1'b0;
    idle_inputs();
  endtask

  initial begin
    // Table starts from reset: pointer favours req0 on the first tie.
    vecs[0] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22,  1, 0, 1, 5'd1, 32'h11);
    vecs[1] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22,  0, 1, 1, 5'd2, 32'h22);
    vecs[2] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22,  1, 0, 1, 5'd1, 32'h11);
    vecs[3] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22,  0, 1, 1, 5'd2, 32'h22);
    vecs[4] = mk(0, 5'd9, 32'h99, 0, 5'd9, 32'h99,  0, 0, 0, 5'd2, 32'h22);
    vecs[5] = mk(0, 5'd0, 32'h0,  1, 5'd0, 32'h1234, 0, 1, 0, 5'd2, 32'h22);
    vecs[6] = mk(0, 5'd0, 32'h0,  1, 5'd7, 32'hCAFE0007, 0, 1, 1, 5'd7, 32'hCAFE0007);
    vecs[7] = mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44,  1, 0, 1, 5'd3, 32'h33);
    vecs[8] = mk(1, 5'd0, 32'h99, 0, 5'd0, 32'h0,   1, 0, 0, 5'd3, 32'h33);
    vecs[9] = mk(1, 5'd3, 32'h55, 1, 5'd4, 32'h44,  0, 1, 1, 5'd4, 32'h44);

    idle_inputs();
    RST = 1'b1;
    step();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      req0_valid = vecs[i].r0v; req0_addr = vecs[i].r0a; req0_data = vecs[i].r0d;
      req1_valid = vecs[i].r1v; req1_addr = vecs[i].r1a; req1_data = vecs[i].r1d;
      #1;
      chk($sformatf("v%0d_r0rdy", i), {31'd0, req0_ready}, {31'd0, vecs[i].e0});
      chk($sformatf("v%0d_r1rdy", i), {31'd0, req1_ready}, {31'd0, vecs[i].e1});
      step();
      chk($sformatf("v%0d_we", i),  {31'd0, WE3}, {31'd0, vecs[i].ewe});
      chk($sformatf("v%0d_a3", i),  {27'd0, A3}, {27'd0, vecs[i].ea});
      chk($sformatf("v%0d_wd3", i), WD3, vecs[i].ewd);
    end
    idle_inputs();

    // Single ALU request straight after reset.
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_r0rdy", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    chk("single_we",  {31'd0, WE3}, 32'd1);
    chk("single_a3",  {27'd0, A3}, 32'd5);
    chk("single_wd3", WD3, 32'hDEADBEEF);

    // req1 handshake leaves pointer at "req1 last" before the sweep.
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    #1;
    chk("pre_clr_r1rdy", {31'd0, req1_ready}, 32'd1);
    step();
    chk("pre_clr_a3", {27'd0, A3}, 32'd6);

    // Clear sweep with both requesters held valid throughout.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    clr_start  = 1'b1;
    #1;
    chk("clr_r0rdy", {31'd0, req0_ready}, 32'd0);
    chk("clr_r1rdy", {31'd0, req1_ready}, 32'd0);
    step();
    clr_start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      clr_start = (i == 5 || i == 31);
      #1;
      chk($sformatf("clr%0d_busy", i), {31'd0, clr_busy}, 32'd1);
      chk($sformatf("clr%0d_rdy", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      clr_start = 1'b0;
      chk($sformatf("clr%0d_we", i),  {31'd0, WE3}, 32'd1);
      chk($sformatf("clr%0d_a3", i),  {27'd0, A3}, i);
      chk($sformatf("clr%0d_wd3", i), WD3, 32'd0);
    end
    #1;
    chk("post_clr_busy",   {31'd0, clr_busy}, 32'd0);
    chk("post_clr_r0rdy",  {31'd0, req0_ready}, 32'd1);
    chk("post_clr_r1rdy",  {31'd0, req1_ready}, 32'd0);
    step();
    chk("post_clr_we", {31'd0, WE3}, 32'd1);
    chk("post_clr_a3", {27'd0, A3}, 32'd9);
    chk("post_clr_wd3", WD3, 32'h99);
    idle_inputs();
    step();
    chk("post_clr_idle_we", {31'd0, WE3}, 32'd0);
    chk("post_clr_busy2",   {31'd0, clr_busy}, 32'd0);

    // Reset in the middle of a sweep, right after the write to register 10.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    chk("mid_a3", {27'd0, A3}, 32'd10);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_we",   {31'd0, WE3}, 32'd0);
    chk("abort_a3",   {27'd0, A3}, 32'd0);
    chk("abort_wd3",  WD3, 32'd0);
    chk("abort_busy", {31'd0, clr_busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort_nowr%0d", i), {31'd0, WE3}, 32'd0);
      chk($sformatf("abort_busy%0d", i), {31'd0, clr_busy}, 32'd0);
    end
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
    req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'hD;
    #1;
    chk("abort_tie_r0", {31'd0, req0_ready}, 32'd1);
    chk("abort_tie_r1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("abort_tie_a3", {27'd0, A3}, 32'd12);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
